// File: rtl/regs_wb_arbiter.sv
// rtl/regs_wb_arbiter.sv - register-file write-port arbiter with destination scoreboard
module regs_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rda,
  input  logic [31:0] ex_rd,
  output logic        ex_ready,
  input  logic        ls_valid,
  input  logic [4:0]  ls_rda,
  input  logic [31:0] ls_rd,
  output logic        ls_ready,
  input  logic        claim_valid,
  input  logic [4:0]  claim_rda,
  output logic        claim_ok,
  input  logic [4:0]  rs1a,
  input  logic [4:0]  rs2a,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  rf_rda,
  output logic [31:0] rf_rd,
  output logic        rf_rdw
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        grant_ex;
  logic        grant_ls;
  logic        rdw_q;
  logic [31:1] busy;
  logic [31:0] busy_vec;
  logic [31:1] busy_next;

  // LS normally wins; EX wins once it has been denied STARVE_LIMIT times in a row
  always_comb begin
    starve_hit = (starve_cnt == LIMIT);
    grant_ex   = !rst && ex_valid && (!ls_valid || starve_hit);
    grant_ls   = !rst && ls_valid && !(ex_valid && starve_hit);
  end

  assign ex_ready = grant_ex;
  assign ls_ready = grant_ls;

  // x0 is never busy, so index 0 of the full vector reads as a constant 0
  assign busy_vec = {busy, 1'b0};
  assign claim_ok = !rst && claim_valid && (claim_rda == 5'd0 || !busy_vec[claim_rda]);
  assign rs1_busy = busy_vec[rs1a];
  assign rs2_busy = busy_vec[rs2a];

  // A write staged for the file is dropped if reset arrives before it commits
  assign rf_rdw = rdw_q && !rst;

  // Count consecutive EX denials; any EX grant or idle EX clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!ex_valid || grant_ex) begin
      starve_cnt <= 4'd0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Register the granted write one cycle ahead of the file; x0 writes are swallowed
  always_ff @(posedge clk) begin
    if (rst) begin
      rdw_q  <= 1'b0;
      rf_rda <= 5'd0;
      rf_rd  <= 32'd0;
    end else if (grant_ls) begin
      rdw_q  <= (ls_rda != 5'd0);
      rf_rda <= ls_rda;
      rf_rd  <= ls_rd;
    end else if (grant_ex) begin
      rdw_q  <= (ex_rda != 5'd0);
      rf_rda <= ex_rda;
      rf_rd  <= ex_rd;
    end else begin
      rdw_q  <= 1'b0;
    end
  end

  // Busy update: committing write clears, accepted claim sets, and set wins a tie
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < 32; i++) begin
      busy_next[i] = (busy[i] && !(rf_rdw && rf_rda == 5'(i)))
                     || (claim_ok && claim_rda == 5'(i));
    end
  end

  // Scoreboard register for x1..x31
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb/tb_regs_wb_arbiter.sv - directed self-checking bench for regs_wb_arbiter
module tb_regs_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rda;
  logic [31:0] ex_rd;
  logic        ex_ready;
  logic        ls_valid;
  logic [4:0]  ls_rda;
  logic [31:0] ls_rd;
  logic        ls_ready;
  logic        claim_valid;
  logic [4:0]  claim_rda;
  logic        claim_ok;
  logic [4:0]  rs1a;
  logic [4:0]  rs2a;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rf_rda;
  logic [31:0] rf_rd;
  logic        rf_rdw;

  int checks = 0;
  int failures = 0;

  regs_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rda(ex_rda), .ex_rd(ex_rd), .ex_ready(ex_ready),
    .ls_valid(ls_valid), .ls_rda(ls_rda), .ls_rd(ls_rd), .ls_ready(ls_ready),
    .claim_valid(claim_valid), .claim_rda(claim_rda), .claim_ok(claim_ok),
    .rs1a(rs1a), .rs2a(rs2a), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_rda(rf_rda), .rf_rd(rf_rd), .rf_rdw(rf_rdw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ls_valid = 0; claim_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_ex;
    bit exp_ex;
    clk = 0; rst = 1;
    ex_valid = 0; ex_rda = 0; ex_rd = 0;
    ls_valid = 0; ls_rda = 0; ls_rd = 0;
    claim_valid = 0; claim_rda = 0; rs1a = 0; rs2a = 0;

    // reset with every request asserted
    step();
    ex_valid = 1; ex_rda = 3; ex_rd = 32'h1;
    ls_valid = 1; ls_rda = 4; ls_rd = 32'h2;
    claim_valid = 1; claim_rda = 5; rs1a = 5;
    #1;
    check("rst_ex_ready", ex_ready, 0);
    check("rst_ls_ready", ls_ready, 0);
    check("rst_claim_ok", claim_ok, 0);
    step(); #1;
    check("rst_rf_rdw", rf_rdw, 0);
    check("rst_rf_rda", rf_rda, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    step(); rst = 0; idle(); #1;
    check("rel_rf_rdw", rf_rdw, 0);
    step(); #1;
    check("idle_rf_rdw", rf_rdw, 0);
    check("idle_rs1_busy", rs1_busy, 0);

    // claim x5, then EX writes x5
    step(); claim_valid = 1; claim_rda = 5; #1;
    check("c5_claim_ok", claim_ok, 1);
    step(); claim_valid = 0; rs1a = 5; #1;
    check("c5_busy_c1", rs1_busy, 1);
    step(); #1;
    check("c5_busy_c2", rs1_busy, 1);
    step(); ex_valid = 1; ex_rda = 5; ex_rd = 32'hDEADBEEF; #1;
    check("c5_ex_ready", ex_ready, 1);
    check("c5_ls_ready", ls_ready, 0);
    step(); ex_valid = 0; #1;
    check("c5_rf_rdw", rf_rdw, 1);
    check("c5_rf_rda", rf_rda, 5);
    check("c5_rf_rd", rf_rd, 32'hDEADBEEF);
    check("c5_busy_c4", rs1_busy, 1);
    step(); #1;
    check("c5_busy_c5", rs1_busy, 0);
    check("c5_rf_rdw_c5", rf_rdw, 0);

    // starvation pattern LS x4 then EX
    prev_ex = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ex_valid = 1; ex_rda = 10; ex_rd = 32'hE0;
      ls_valid = 1; ls_rda = 11; ls_rd = 32'hA0;
      #1;
      exp_ex = (i % 5 == 4);
      check($sformatf("stv_ex_ready_%0d", i), ex_ready, exp_ex);
      check($sformatf("stv_ls_ready_%0d", i), ls_ready, !exp_ex);
      if (i > 0) begin
        check($sformatf("stv_rf_rda_%0d", i), rf_rda, prev_ex ? 10 : 11);
        check($sformatf("stv_rf_rdw_%0d", i), rf_rdw, 1);
      end
      prev_ex = exp_ex;
    end
    step(); idle(); #1;
    check("stv_last_rda", rf_rda, 10);
    check("stv_last_rd", rf_rd, 32'hE0);

    // WAW stall on x7 and claim on the commit edge
    step(); claim_valid = 1; claim_rda = 7; #1;
    check("c7_first_ok", claim_ok, 1);
    step(); rs2a = 7; #1;
    check("c7_busy_ok", claim_ok, 0);
    check("c7_rs2_busy", rs2_busy, 1);
    step(); claim_valid = 0; ls_valid = 1; ls_rda = 7; ls_rd = 32'h77; #1;
    check("c7_ls_ready", ls_ready, 1);
    check("c7_still_busy", rs2_busy, 1);
    step(); ls_valid = 0; claim_valid = 1; claim_rda = 7; #1;
    check("c7_commit_rdw", rf_rdw, 1);
    check("c7_commit_rda", rf_rda, 7);
    check("c7_commit_ok", claim_ok, 0);
    step(); #1;
    check("c7_cleared", rs2_busy, 0);
    check("c7_after_ok", claim_ok, 1);
    step(); claim_valid = 0; #1;
    check("c7_reclaimed", rs2_busy, 1);

    // x0 write and x0 claim
    step(); ls_valid = 1; ls_rda = 0; ls_rd = 32'h12345678;
    claim_valid = 1; claim_rda = 0; rs2a = 0; #1;
    check("x0_ls_ready", ls_ready, 1);
    check("x0_claim_ok", claim_ok, 1);
    step(); idle(); #1;
    check("x0_rf_rdw", rf_rdw, 0);
    check("x0_rf_rda", rf_rda, 0);
    check("x0_rf_rd", rf_rd, 32'h12345678);
    check("x0_rs2_busy", rs2_busy, 0);

    // reset right after an EX accept to claimed x9
    step(); claim_valid = 1; claim_rda = 9; #1;
    check("c9_claim_ok", claim_ok, 1);
    step(); claim_valid = 0; ex_valid = 1; ex_rda = 9; ex_rd = 32'h99; #1;
    check("c9_ex_ready", ex_ready, 1);
    step(); rst = 1; ex_valid = 1; ex_rda = 9; ls_valid = 1; ls_rda = 2;
    claim_valid = 1; claim_rda = 3; #1;
    check("c9_rst_rdw", rf_rdw, 0);
    check("c9_rst_ex_ready", ex_ready, 0);
    check("c9_rst_ls_ready", ls_ready, 0);
    check("c9_rst_claim_ok", claim_ok, 0);
    step(); rst = 0; idle(); rs1a = 9; rs2a = 7; #1;
    check("c9_post_rdw", rf_rdw, 0);
    check("c9_post_rda", rf_rda, 0);
    check("c9_post_rd", rf_rd, 0);
    check("c9_busy9", rs1_busy, 0);
    check("c9_busy7", rs2_busy, 0);

    // reset clears a partially built starvation count
    for (int i = 0; i < 3; i++) begin
      step(); ex_valid = 1; ex_rda = 1; ls_valid = 1; ls_rda = 2; #1;
      check($sformatf("sr_pre_ls_%0d", i), ls_ready, 1);
    end
    step(); rst = 1; #1;
    check("sr_rst_ex_ready", ex_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step(); rst = 0; #1;
      check($sformatf("sr_ex_ready_%0d", i), ex_ready, i == 4);
      check($sformatf("sr_ls_ready_%0d", i), ls_ready, i != 4);
    end
    step(); idle(); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
